// File: rtl/time_core_pkg.sv
// Shared definitions for the time-of-day core: mode encoding, BCD field limits,
// blank-mask bit positions and the two-digit BCD increment.
`timescale 1ns/1ps
package time_core_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_e;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  localparam int BLANK_HOUR_LSB = 4;
  localparam int BLANK_MIN_LSB  = 2;
  localparam int BLANK_SEC_LSB  = 0;

  // Synchronizer lane assignment; the 2 Hz flash lane needs no edge detector.
  localparam int IDX_1HZ  = 0;
  localparam int IDX_MODE = 1;
  localparam int IDX_INC  = 2;
  localparam int IDX_2HZ  = 3;
  localparam int N_SYNC   = 4;
  localparam int N_EDGE   = 3;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] >= 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
      r[7:4] = v[7:4];
    end
    return r;
  endfunction

endpackage

// File: rtl/time_core_bcd_cnt.sv
// Two-digit BCD counter that wraps to 00 after reaching max; carry flags the wrap.
`timescale 1ns/1ps
module bcd_cnt
  import time_core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic [7:0] max,
  output logic [7:0] value,
  output logic       carry
);

  logic [7:0] value_q;
  logic [7:0] value_d;

  always_comb begin
    value_d = value_q;
    if (inc) begin
      // ">=" keeps the field in range even if it were ever corrupted.
      if (value_q >= max) value_d = 8'h00;
      else                value_d = bcd_inc(value_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= 8'h00;
    else     value_q <= value_d;
  end

  assign value = value_q;
  assign carry = inc && (value_q == max);

endmodule

// File: rtl/time_core.sv
// Time-of-day core: synchronized tick/key inputs, RUN/SET mode FSM, three chained
// BCD counters and a registered per-digit flash mask for the display scanner.
`timescale 1ns/1ps
module time_core
  import time_core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1Hz,
  input  logic       clk_2Hz,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] mode,
  output logic [5:0] blank
);

  logic [N_SYNC-1:0] raw_in;
  logic [N_SYNC-1:0] sync1_q, sync1_d;
  logic [N_SYNC-1:0] sync2_q, sync2_d;
  logic [N_EDGE-1:0] prev_q, prev_d;
  logic [N_EDGE-1:0] rise;

  assign raw_in[IDX_1HZ]  = clk_1Hz;
  assign raw_in[IDX_MODE] = key_mode;
  assign raw_in[IDX_INC]  = key_inc;
  assign raw_in[IDX_2HZ]  = clk_2Hz;

  // Reset to all-ones so a level held high across reset never looks like an edge.
  generate
    for (genvar gi = 0; gi < N_SYNC; gi++) begin : g_sync
      always_comb begin
        sync1_d[gi] = raw_in[gi];
        sync2_d[gi] = sync1_q[gi];
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_q[gi] <= 1'b1;
          sync2_q[gi] <= 1'b1;
        end else begin
          sync1_q[gi] <= sync1_d[gi];
          sync2_q[gi] <= sync2_d[gi];
        end
      end
    end
    for (genvar gi = 0; gi < N_EDGE; gi++) begin : g_edge
      always_comb prev_d[gi] = sync2_q[gi];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q[gi] <= 1'b1;
        else     prev_q[gi] <= prev_d[gi];
      end
      assign rise[gi] = sync2_q[gi] & ~prev_q[gi];
    end
  endgenerate

  logic tick, mode_p, inc_p, flash_on;
  assign tick     = rise[IDX_1HZ];
  assign mode_p   = rise[IDX_MODE];
  assign inc_p    = rise[IDX_INC];
  assign flash_on = sync2_q[IDX_2HZ];

  state_e     state_q, state_d;
  logic [5:0] blank_q, blank_d;
  logic       inc_ok, running;
  logic       sec_inc, min_inc, hour_inc;
  logic       sec_carry, min_carry, day_wrap_unused;

  always_comb begin
    state_d = state_q;
    if (mode_p) begin
      unique case (state_q)
        RUN:     state_d = SET_H;
        SET_H:   state_d = SET_M;
        SET_M:   state_d = SET_S;
        default: state_d = RUN;
      endcase
    end
  end

  // A simultaneous mode press swallows the increment.
  assign inc_ok  = inc_p & ~mode_p;
  assign running = (state_q == RUN);

  assign sec_inc  = (running & tick)      | ((state_q == SET_S) & inc_ok);
  assign min_inc  = (running & sec_carry) | ((state_q == SET_M) & inc_ok);
  assign hour_inc = (running & min_carry) | ((state_q == SET_H) & inc_ok);

  always_comb begin
    blank_d = 6'b000000;
    if (!flash_on) begin
      unique case (state_q)
        SET_H:   blank_d[BLANK_HOUR_LSB +: 2] = 2'b11;
        SET_M:   blank_d[BLANK_MIN_LSB  +: 2] = 2'b11;
        SET_S:   blank_d[BLANK_SEC_LSB  +: 2] = 2'b11;
        default: blank_d = 6'b000000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      blank_q <= 6'b000000;
    end else begin
      state_q <= state_d;
      blank_q <= blank_d;
    end
  end

  bcd_cnt u_sec (
    .clk   (clk),
    .rst   (rst),
    .inc   (sec_inc),
    .max   (SEC_MAX),
    .value (sec_bcd),
    .carry (sec_carry)
  );

  bcd_cnt u_min (
    .clk   (clk),
    .rst   (rst),
    .inc   (min_inc),
    .max   (MIN_MAX),
    .value (min_bcd),
    .carry (min_carry)
  );

  bcd_cnt u_hour (
    .clk   (clk),
    .rst   (rst),
    .inc   (hour_inc),
    .max   (HOUR_MAX),
    .value (hour_bcd),
    .carry (day_wrap_unused)
  );

  assign mode  = state_q;
  assign blank = blank_q;

endmodule

// File: tb/tb_time_core.sv
// Directed + randomized bench for time_core against an integer-arithmetic clock model.
`timescale 1ns/1ps
module tb_time_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_1Hz, clk_2Hz, key_mode, key_inc;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic [1:0] mode;
  logic [5:0] blank;

  int total = 0;
  int bad   = 0;

  // Reference model: plain integers for h/m/s and mode 0..3.
  int mh, mm, ms, mmode;
  bit cur_2hz;

  time_core dut (
    .clk      (clk),
    .rst      (rst),
    .clk_1Hz  (clk_1Hz),
    .clk_2Hz  (clk_2Hz),
    .key_mode (key_mode),
    .key_inc  (key_inc),
    .hour_bcd (hour_bcd),
    .min_bcd  (min_bcd),
    .sec_bcd  (sec_bcd),
    .mode     (mode),
    .blank    (blank)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [7:0] exp_blank();
    if (mmode == 0 || cur_2hz) return 8'h00;
    if (mmode == 1) return 8'h30;
    if (mmode == 2) return 8'h0C;
    return 8'h03;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s, input int md);
    chk({tag, "_hour"}, hour_bcd, to_bcd(h));
    chk({tag, "_min"},  min_bcd,  to_bcd(m));
    chk({tag, "_sec"},  sec_bcd,  to_bcd(s));
    chk({tag, "_mode"}, {6'd0, mode}, 8'(md));
  endtask

  task automatic model_apply(input bit t, input bit m, input bit i);
    if (mmode == 0 && t) begin
      int secs;
      secs = (mh * 3600 + mm * 60 + ms + 1) % 86400;
      mh = secs / 3600;
      mm = (secs / 60) % 60;
      ms = secs % 60;
    end
    if (m) mmode = (mmode + 1) % 4;
    else if (i) begin
      if (mmode == 1) mh = (mh + 1) % 24;
      if (mmode == 2) mm = (mm + 1) % 60;
      if (mmode == 3) ms = (ms + 1) % 60;
    end
  endtask

  // One transaction: raise the selected lines, verify nothing moves on edges 1-2,
  // verify the update lands on edge 3, then drop the lines and check the flash mask.
  task automatic op(input string tag, input bit t, input bit m, input bit i, input bit c2);
    int oh, om, os, omd;
    @(negedge clk);
    clk_1Hz = t; key_mode = m; key_inc = i; clk_2Hz = c2; cur_2hz = c2;
    oh = mh; om = mm; os = ms; omd = mmode;
    model_apply(t, m, i);
    repeat (2) @(posedge clk);
    #1 chk_time({tag, "_early"}, oh, om, os, omd);
    @(posedge clk);
    #1 chk_time({tag, "_edge3"}, mh, mm, ms, mmode);
    @(negedge clk);
    clk_1Hz = 1'b0; key_mode = 1'b0; key_inc = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk({tag, "_blank"}, {2'b00, blank}, exp_blank());
    $display("op %s t=%0b m=%0b i=%0b c2=%0b -> %0d:%0d:%0d mode=%0d", tag, t, m, i, c2, mh, mm, ms, mmode);
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) op("inc", 1'b0, 1'b0, 1'b1, cur_2hz);
  endtask

  task automatic set_2hz(input string tag, input bit v);
    @(negedge clk);
    clk_2Hz = v; cur_2hz = v;
    repeat (4) @(posedge clk);
    #1 chk(tag, {2'b00, blank}, exp_blank());
    $display("flash %s clk_2Hz=%0b blank=%06b", tag, v, blank);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mh = 0; mm = 0; ms = 0; mmode = 0;
  endtask

  initial begin
    int r;
    // Reset release with every input held high: no spurious pulses.
    rst = 1'b1; clk_1Hz = 1'b1; clk_2Hz = 1'b1; key_mode = 1'b1; key_inc = 1'b1;
    cur_2hz = 1'b1; mh = 0; mm = 0; ms = 0; mmode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk_time("rst_high", 0, 0, 0, 0);
    chk("rst_high_blank", {2'b00, blank}, 8'h00);
    $display("reset release with inputs high: %h:%h:%h mode=%0d", hour_bcd, min_bcd, sec_bcd, mode);
    @(negedge clk);
    clk_1Hz = 1'b0; key_mode = 1'b0; key_inc = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk_time("after_fall", 0, 0, 0, 0);

    // Preload 23:59:59 and roll over with one tick.
    op("to_set_h", 1'b0, 1'b1, 1'b0, 1'b1); incs(23);
    op("to_set_m", 1'b0, 1'b1, 1'b0, 1'b1); incs(59);
    op("to_set_s", 1'b0, 1'b1, 1'b0, 1'b1); incs(59);
    op("to_run", 1'b0, 1'b1, 1'b0, 1'b1);
    op("run_inc_ignored", 1'b0, 1'b0, 1'b1, 1'b1);
    op("midnight", 1'b1, 1'b0, 1'b0, 1'b1);
    chk_time("midnight_abs", 0, 0, 0, 0);

    // SET_M at 59: ticks frozen, inc wraps minutes without carry.
    op("to_set_h2", 1'b0, 1'b1, 1'b0, 1'b1);
    op("to_set_m2", 1'b0, 1'b1, 1'b0, 1'b1);
    incs(59);
    for (int k = 0; k < 5; k++) op("frozen_tick", 1'b1, 1'b0, 1'b0, 1'b1);
    op("min_wrap", 1'b0, 1'b0, 1'b1, 1'b1);
    chk_time("min_wrap_abs", 0, 0, 0, 2);

    // Mode and inc together in SET_H: mode wins.
    op("to_set_s2", 1'b0, 1'b1, 1'b0, 1'b1);
    op("to_run2", 1'b0, 1'b1, 1'b0, 1'b1);
    op("to_set_h3", 1'b0, 1'b1, 1'b0, 1'b1);
    op("mode_inc_both", 1'b0, 1'b1, 1'b1, 1'b1);
    chk_time("mode_wins_abs", 0, 0, 0, 2);

    // Flash mask in SET_S, then dark-free in RUN.
    op("to_set_s3", 1'b0, 1'b1, 1'b0, 1'b1);
    set_2hz("flash_sets_low", 1'b0);
    chk("flash_sets_low_abs", {2'b00, blank}, 8'h03);
    set_2hz("flash_sets_high", 1'b1);
    chk("flash_sets_high_abs", {2'b00, blank}, 8'h00);
    op("to_run3", 1'b0, 1'b1, 1'b0, 1'b0);
    set_2hz("flash_run_low", 1'b0);
    chk("flash_run_low_abs", {2'b00, blank}, 8'h00);

    // Tick and mode together in RUN: tick applied, then SET_H.
    op("tick_mode", 1'b1, 1'b1, 1'b0, 1'b0);
    op("back_m", 1'b0, 1'b1, 1'b0, 1'b0);
    op("back_s", 1'b0, 1'b1, 1'b0, 1'b0);
    op("back_run", 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized mix of ticks, keys and flash levels.
    for (int k = 0; k < 120; k++) begin
      r = int'($urandom_range(0, 6));
      case (r)
        0: op("rnd_tick", 1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        1: op("rnd_mode", 1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        2, 3: op("rnd_inc", 1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
        4: op("rnd_mode_inc", 1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
        5: op("rnd_tick_mode", 1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        default: op("rnd_tick_inc", 1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
      endcase
    end

    // Reach SET_M at 12:34:56, then reset asynchronously with a mode pulse pending.
    do_reset();
    repeat (4) @(posedge clk);
    op("p_set_h", 1'b0, 1'b1, 1'b0, 1'b1); incs(12);
    op("p_set_m", 1'b0, 1'b1, 1'b0, 1'b1); incs(34);
    op("p_set_s", 1'b0, 1'b1, 1'b0, 1'b1); incs(56);
    op("p_run", 1'b0, 1'b1, 1'b0, 1'b1);
    op("p_set_h2", 1'b0, 1'b1, 1'b0, 1'b1);
    op("p_set_m2", 1'b0, 1'b1, 1'b0, 1'b0);
    chk_time("preset_1234", 12, 34, 56, 2);
    @(negedge clk) key_mode = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_time("async_rst", 0, 0, 0, 0);
    chk("async_rst_blank", {2'b00, blank}, 8'h00);
    $display("async reset mid-cycle: %h:%h:%h mode=%0d blank=%06b", hour_bcd, min_bcd, sec_bcd, mode, blank);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    mh = 0; mm = 0; ms = 0; mmode = 0;
    repeat (6) @(posedge clk);
    #1 chk_time("no_pending_pulse", 0, 0, 0, 0);
    @(negedge clk) key_mode = 1'b0;
    repeat (4) @(posedge clk);
    op("post_rst_tick", 1'b1, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_core.md
TIME_CORE -- requirements
Module: time_core

Interface
REQ-001 Parameters: none; all moduli come from the shared package.
REQ-002 clk  in  1  100 MHz system clock; sole clock of the block.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 clk_1Hz  in  1  1 Hz square wave from the clock divider, sampled as data; its rising edge is one timing tick.
REQ-005 clk_2Hz  in  1  2 Hz square wave from the clock divider, sampled as data; drives the adjust-mode flash.
REQ-006 key_mode  in  1  debounced mode key level, active-high.
REQ-007 key_inc  in  1  debounced increment key level, active-high.
REQ-008 hour_bcd  out  8  hours, two BCD digits, 00-23.
REQ-009 min_bcd  out  8  minutes, two BCD digits, 00-59.
REQ-010 sec_bcd  out  8  seconds, two BCD digits, 00-59.
REQ-011 mode  out  2  current state encoding: RUN=0, SET_H=1, SET_M=2, SET_S=3.
REQ-012 blank  out  6  per-digit blank mask for the scanner; bit order [5:4]=hour, [3:2]=min, [1:0]=sec; 1 = digit dark.

Function
REQ-013 Each of clk_1Hz, clk_2Hz, key_mode and key_inc SHALL pass through a 2-flop synchronizer.
REQ-014 Each of clk_1Hz, key_mode and key_inc SHALL have a rising-edge detector that yields a one-clk pulse: tick, mode_p and inc_p respectively.
REQ-015 A counter or state update SHALL occur on exactly the 3rd clk rising edge after the first edge that samples the input high.
REQ-016 The FSM SHALL have four states, RUN, SET_H, SET_M and SET_S; mode_p SHALL step them in the order RUN->SET_H->SET_M->SET_S->RUN.
REQ-017 In RUN, a tick SHALL increment sec; sec 59->00 SHALL carry to min; min 59->00 SHALL carry to hour; hour 23->00 SHALL wrap.
REQ-018 In RUN, 23:59:59 plus a tick SHALL give 00:00:00 in a single cycle.
REQ-019 In RUN, inc_p SHALL be ignored.
REQ-020 In SET_x states, ticks SHALL be ignored and time SHALL be frozen.
REQ-021 In SET_x states, inc_p SHALL increment only the selected field modulo its range (24 or 60) with no carry into any other field.
REQ-022 If mode_p and inc_p occur in the same cycle, mode_p SHALL win and inc_p SHALL be dropped.
REQ-023 If a tick and mode_p occur in the same cycle in RUN, the tick SHALL be applied and the state SHALL then advance to SET_H.
REQ-024 In SET_x states, both digits of the selected field SHALL have blank=1 while the synchronized clk_2Hz is 0; all other blank bits SHALL be 0.
REQ-025 In RUN, blank SHALL be 000000.
REQ-026 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-027 BCD digits SHALL never hold codes A-F, and no field SHALL ever exceed its range.

Reset
REQ-028 rst SHALL force hour_bcd, min_bcd and sec_bcd to 8'h00, mode to RUN and blank to 000000.
REQ-029 rst SHALL set all synchronizer and edge-detect flops to 1, so that an input held high through reset produces no pulse.
REQ-030 rst asserted mid-operation, in any state, SHALL abort immediately; no pending pulse SHALL survive reset.

Structure
REQ-031 A shared package SHALL hold: the state enum (RUN, SET_H, SET_M, SET_S), the BCD moduli constants (SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR_MAX=8'h23) and the blank bit-position constants.
REQ-032 One sub-module, bcd_cnt, SHALL implement a two-digit BCD counter with inputs inc and max and outputs value and carry (carry = inc and value==max).
REQ-033 time_core SHALL instantiate bcd_cnt three times.

Verification
REQ-034 Reset release with all inputs high -> 00:00:00, mode=0, blank=0; no increment occurs.
REQ-035 Preload 23:59:59 via SET states, return to RUN, apply one clk_1Hz rising edge -> 00:00:00 exactly 3 clk edges later.
REQ-036 In SET_M with min=59, one key_inc pulse -> min=00, with hour and sec unchanged; 5 ticks meanwhile -> sec unchanged.
REQ-037 key_mode and key_inc rise in the same cycle while in SET_H -> mode=2 and hour unchanged.
REQ-038 In SET_S, toggle clk_2Hz -> blank=000011 while clk_2Hz is low and 000000 while high; in RUN, blank stays 000000.
REQ-039 rst asserted while in SET_M with time 12:34:56 -> outputs 00:00:00 and mode=0 asynchronously, before the next clk edge.
